mips_spbmsram_arb: RTL and testbench

- Two-requester arbiter and sequencer in front of one single-port bit-masked SRAM configured for registered read, i.e. read data valid one cycle after the access.
- Requester 0 is the instruction-fetch path; requester 1 is the load/store path.
- Grants at most one access per cycle.
- Routes returned read data to the owning requester.
- Supports a lock for atomic read-modify-write sequences.

---
 rtl/mips_cbb_pkg.sv | 20 ++
 rtl/mips_rr_arb2.sv | 29 ++
 rtl/mips_spbmsram_arb.sv | 134 +++++++++++++
 tb/tb_mips_spbmsram_arb.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cbb_pkg.sv
// Shared encodings for the MIPS SRAM arbiter slice: FSM states, arbitration
// modes and read-return owner.
package mips_cbb_pkg;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

endpackage

// File: rtl/mips_rr_arb2.sv
// Two-way picker: round-robin against last_gnt, or fixed priority with
// requester 0 highest. Output is one-hot (or zero when nobody requests).
module mips_rr_arb2
    import mips_cbb_pkg::*;
#(
    parameter int ARB_MODE = ARB_RR
) (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    // Conflict goes to the requester that did not win last, unless fixed mode
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (ARB_MODE == ARB_FIXED || last_gnt)
                    gnt = 2'b01;
                else
                    gnt = 2'b10;
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mips_spbmsram_arb.sv
// Two-requester arbiter in front of a single-port bit-masked SRAM with
// registered read. Handles lock ownership for read-modify-write sequences
// and steers the one-cycle-late read data back to the requester that owns it.
module mips_spbmsram_arb
    import mips_cbb_pkg::*;
#(
    parameter int MEM_WIDTH  = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int ARB_MODE   = ARB_RR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_lock,
    input  logic                  m0_wen,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [MEM_WIDTH-1:0]  m0_din,
    input  logic [MEM_WIDTH-1:0]  m0_wbeb,
    input  logic                  m1_req,
    input  logic                  m1_lock,
    input  logic                  m1_wen,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [MEM_WIDTH-1:0]  m1_din,
    input  logic [MEM_WIDTH-1:0]  m1_wbeb,
    output logic                  m0_gnt,
    output logic                  m1_gnt,
    output logic                  m0_rvalid,
    output logic                  m1_rvalid,
    output logic [MEM_WIDTH-1:0]  m0_rdata,
    output logic [MEM_WIDTH-1:0]  m1_rdata,
    output logic                  mem_ce,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_WIDTH-1:0]  mem_din,
    output logic [MEM_WIDTH-1:0]  mem_wbeb,
    input  logic [MEM_WIDTH-1:0]  mem_dout
);

    arb_state_t state_q, state_d;
    logic       last_gnt_q, last_gnt_d;   // index of the last winner
    owner_t     rd_owner_q, rd_owner_d;   // who gets mem_dout next cycle
    logic [1:0] req_elig;
    logic [1:0] gnt_raw;
    logic [1:0] gnt;

    // Eligibility: a lock shuts out the other requester entirely
    always_comb begin
        req_elig = {m1_req, m0_req};
        case (state_q)
            ST_ARB:   req_elig = {m1_req, m0_req};
            ST_LOCK0: req_elig = {1'b0, m0_req};
            ST_LOCK1: req_elig = {m1_req, 1'b0};
            default:  req_elig = {m1_req, m0_req};
        endcase
    end

    mips_rr_arb2 #(
        .ARB_MODE (ARB_MODE)
    ) u_pick (
        .req      (req_elig),
        .last_gnt (last_gnt_q),
        .gnt      (gnt_raw)
    );

    // Nothing may reach the SRAM while reset is held
    assign gnt    = rst_n ? gnt_raw : 2'b00;
    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    // SRAM port mux; idle cycles drive all-zero so the bus is quiet
    always_comb begin
        mem_ce   = 1'b0;
        mem_wen  = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        mem_wbeb = '0;
        if (gnt[0]) begin
            mem_ce   = 1'b1;
            mem_wen  = m0_wen;
            mem_addr = m0_addr;
            mem_din  = m0_din;
            mem_wbeb = m0_wbeb;
        end else if (gnt[1]) begin
            mem_ce   = 1'b1;
            mem_wen  = m1_wen;
            mem_addr = m1_addr;
            mem_din  = m1_din;
            mem_wbeb = m1_wbeb;
        end
    end

    // Next state, round-robin history and read-return owner
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        rd_owner_d = OWN_NONE;
        if (gnt[0]) begin
            last_gnt_d = 1'b0;
            if (!m0_wen) rd_owner_d = OWN_M0;
        end else if (gnt[1]) begin
            last_gnt_d = 1'b1;
            if (!m1_wen) rd_owner_d = OWN_M1;
        end
        case (state_q)
            ST_ARB: begin
                if (gnt[0] && m0_lock)      state_d = ST_LOCK0;
                else if (gnt[1] && m1_lock) state_d = ST_LOCK1;
            end
            // Release on an unlocked access or when the owner drops req
            ST_LOCK0: if (!m0_req || (gnt[0] && !m0_lock)) state_d = ST_ARB;
            ST_LOCK1: if (!m1_req || (gnt[1] && !m1_lock)) state_d = ST_ARB;
            default:  state_d = ST_ARB;
        endcase
    end

    // State registers; reset drops locks and any in-flight read return
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_ARB;
            last_gnt_q <= 1'b1;
            rd_owner_q <= OWN_NONE;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign m0_rvalid = (rd_owner_q == OWN_M0);
    assign m1_rvalid = (rd_owner_q == OWN_M1);
    assign m0_rdata  = m0_rvalid ? mem_dout : '0;
    assign m1_rdata  = m1_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_mips_spbmsram_arb.sv
// Directed bench for mips_spbmsram_arb: a round-robin instance with a
// behavioural bit-masked SRAM, plus a fixed-priority instance on the same
// requests used only for grant counting.
module tb_mips_spbmsram_arb;

    localparam int MW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_lock, m0_wen, m1_req, m1_lock, m1_wen;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [MW-1:0] m0_din, m0_wbeb, m1_din, m1_wbeb;

    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [MW-1:0] m0_rdata, m1_rdata;
    logic          mem_ce, mem_wen;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] mem_din, mem_wbeb, mem_dout;

    logic          f_m0_gnt, f_m1_gnt, f_m0_rvalid, f_m1_rvalid;
    logic [MW-1:0] f_m0_rdata, f_m1_rdata;
    logic          f_mem_ce, f_mem_wen;
    logic [AW-1:0] f_mem_addr;
    logic [MW-1:0] f_mem_din, f_mem_wbeb;
    logic [MW-1:0] f_mem_dout = '0;

    logic [MW-1:0] mem [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;
    int rr_m0, rr_m1, fp_m0, fp_m1;

    always #5 clk = ~clk;

    mips_spbmsram_arb #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW), .ARB_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_wen(m0_wen), .m0_addr(m0_addr),
        .m0_din(m0_din), .m0_wbeb(m0_wbeb),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_wen(m1_wen), .m1_addr(m1_addr),
        .m1_din(m1_din), .m1_wbeb(m1_wbeb),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_ce(mem_ce), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_wbeb(mem_wbeb), .mem_dout(mem_dout)
    );

    mips_spbmsram_arb #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW), .ARB_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_wen(m0_wen), .m0_addr(m0_addr),
        .m0_din(m0_din), .m0_wbeb(m0_wbeb),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_wen(m1_wen), .m1_addr(m1_addr),
        .m1_din(m1_din), .m1_wbeb(m1_wbeb),
        .m0_gnt(f_m0_gnt), .m1_gnt(f_m1_gnt), .m0_rvalid(f_m0_rvalid), .m1_rvalid(f_m1_rvalid),
        .m0_rdata(f_m0_rdata), .m1_rdata(f_m1_rdata),
        .mem_ce(f_mem_ce), .mem_wen(f_mem_wen), .mem_addr(f_mem_addr), .mem_din(f_mem_din),
        .mem_wbeb(f_mem_wbeb), .mem_dout(f_mem_dout)
    );

    // Behavioural SRAM: bit-masked write, registered read
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_wen) mem[mem_addr] <= (mem[mem_addr] & ~mem_wbeb) | (mem_din & mem_wbeb);
            else         mem_dout <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    task automatic idle_all();
        m0_req = 0; m0_lock = 0; m0_wen = 0; m0_addr = '0; m0_din = '0; m0_wbeb = '0;
        m1_req = 0; m1_lock = 0; m1_wen = 0; m1_addr = '0; m1_din = '0; m1_wbeb = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000_0000 | i;
        mem[8'h05] = 32'h0000_0000;
        mem_dout = '0;
        idle_all();
        rst_n = 0;
        m0_req = 1;                      // request during reset must be ignored
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt",    {m1_gnt, m0_gnt}, 0);
        chk("rst_ce",     mem_ce, 0);
        chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);

        // Two simultaneous reads out of reset: m0 first, then m1
        next_cyc();
        rst_n = 1;
        m0_addr = 8'h10; m1_req = 1; m1_addr = 8'h20;
        @(negedge clk);
        chk("t1_gnt_T",  {m1_gnt, m0_gnt}, 2'b01);
        chk("t1_addr_T", mem_addr, 8'h10);
        next_cyc();
        m0_req = 0;
        @(negedge clk);
        chk("t1_gnt_T1",    {m1_gnt, m0_gnt}, 2'b10);
        chk("t1_m0_rvalid", m0_rvalid, 1);
        chk("t1_m0_rdata",  m0_rdata, 32'h1000_0010);
        chk("t1_m1_rdata0", m1_rdata, 0);
        next_cyc();
        m1_req = 0;
        @(negedge clk);
        chk("t1_m1_rvalid", {m1_rvalid, m0_rvalid}, 2'b10);
        chk("t1_m1_rdata",  m1_rdata, 32'h1000_0020);

        // Continuous contention for 8 cycles
        next_cyc();
        m0_req = 1; m0_addr = 8'h01; m1_req = 1; m1_addr = 8'h02;
        rr_m0 = 0; rr_m1 = 0; fp_m0 = 0; fp_m1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_rr_alt", m0_gnt, (i % 2 == 0) ? 1 : 0);
            rr_m0 += m0_gnt; rr_m1 += m1_gnt;
            fp_m0 += f_m0_gnt; fp_m1 += f_m1_gnt;
            next_cyc();
        end
        idle_all();
        chk("t2_rr_m0", rr_m0, 4);
        chk("t2_rr_m1", rr_m1, 4);
        chk("t2_fp_m0", fp_m0, 8);
        chk("t2_fp_m1", fp_m1, 0);

        // Masked write by m1, then read back by m0
        m1_req = 1; m1_wen = 1; m1_addr = 8'h05; m1_din = 32'hDEAD_BEEF; m1_wbeb = 32'hFFFF_0000;
        @(negedge clk);
        chk("t3_wr_gnt",  {m1_gnt, m0_gnt}, 2'b10);
        chk("t3_wr_wen",  mem_wen, 1);
        chk("t3_wr_wbeb", mem_wbeb, 32'hFFFF_0000);
        next_cyc();
        idle_all();
        m0_req = 1; m0_addr = 8'h05;
        @(negedge clk);
        chk("t3_rd_gnt",     {m1_gnt, m0_gnt}, 2'b01);
        chk("t3_wr_novalid", m1_rvalid, 0);
        next_cyc();
        idle_all();
        @(negedge clk);
        chk("t3_rd_rvalid", m0_rvalid, 1);
        chk("t3_rd_rdata",  m0_rdata, 32'hDEAD_0000);

        // Locked read-modify-write by m1 while m0 keeps requesting
        m0_req = 1; m0_addr = 8'h40;
        m1_req = 1; m1_lock = 1; m1_addr = 8'h30;
        @(negedge clk);
        chk("t4_lock_rd_gnt", {m1_gnt, m0_gnt}, 2'b10);
        next_cyc();
        m1_wen = 1; m1_lock = 0; m1_din = 32'h1234_5678; m1_wbeb = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("t4_lock_wr_gnt", {m1_gnt, m0_gnt}, 2'b10);
        chk("t4_lock_rdata",  m1_rdata, 32'h1000_0030);
        next_cyc();
        m1_req = 0; m1_wen = 0;
        @(negedge clk);
        chk("t4_m0_after", {m1_gnt, m0_gnt}, 2'b01);
        chk("t4_m0_addr",  mem_addr, 8'h40);
        next_cyc();
        idle_all();

        // Lock released by the owner dropping req: dead cycle, then m0
        m1_req = 1; m1_lock = 1; m1_addr = 8'h31;
        @(negedge clk);
        chk("t4b_lock_gnt", {m1_gnt, m0_gnt}, 2'b10);
        next_cyc();
        idle_all();
        m0_req = 1; m0_addr = 8'h41;
        @(negedge clk);
        chk("t4b_dead_gnt", {m1_gnt, m0_gnt}, 2'b00);
        chk("t4b_dead_ce",  mem_ce, 0);
        next_cyc();
        @(negedge clk);
        chk("t4b_m0_gnt", {m1_gnt, m0_gnt}, 2'b01);
        next_cyc();
        idle_all();

        // Reset right after a locked read grant
        m1_req = 1; m1_lock = 1; m1_addr = 8'h22;
        @(negedge clk);
        chk("t5_pre_gnt", {m1_gnt, m0_gnt}, 2'b10);
        rst_n = 0;
        next_cyc();
        @(negedge clk);
        chk("t5_no_rvalid", {m1_rvalid, m0_rvalid}, 0);
        chk("t5_rst_ce",    mem_ce, 0);
        next_cyc();
        rst_n = 1;
        m1_lock = 0; m1_addr = 8'h20; m0_req = 1; m0_addr = 8'h10;
        @(negedge clk);
        chk("t5_post_gnt", {m1_gnt, m0_gnt}, 2'b01);
        next_cyc();
        m0_req = 0;
        @(negedge clk);
        chk("t5_post_gnt2",  {m1_gnt, m0_gnt}, 2'b10);
        chk("t5_post_rdata", m0_rdata, 32'h1000_0010);
        next_cyc();
        idle_all();
        next_cyc();

        // Quiet bus
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_idle_ctl",   {mem_ce, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 0);
            chk("t6_idle_rdata", {m0_rdata, m1_rdata}, 0);
            next_cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
